// File: rtl/demux8_deser.sv
// Serial-to-parallel 1:LANES demultiplexer with a one-entry
// valid/ready word buffer and frame realignment.
module demux8_deser #(
  parameter int LANES = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [SEL_W-1:0] sel_o,
  output logic [LANES-1:0] word_o,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [LANES-2:0] lanes_q, lanes_d;
  logic [LANES-1:0] word_q, word_d;
  logic             wvld_q, wvld_d;
  logic             ferr_q, ferr_d;
  logic             at_last, stall, beat, consume;

  always_comb begin
    at_last = (sel_q == LAST);
    stall   = at_last && wvld_q && !word_ready;
    // a new frame restarts at slot 0, so it never waits on the buffer
    bit_ready = frame_start || !stall;
    beat      = bit_valid && bit_ready;
    consume   = wvld_q && word_ready;
  end

  always_comb begin
    sel_d   = sel_q;
    lanes_d = lanes_q;
    word_d  = word_q;
    wvld_d  = wvld_q;
    ferr_d  = frame_start && (sel_q != '0);
    if (consume) wvld_d = 1'b0;
    if (frame_start) begin
      lanes_d = '0;
      sel_d   = '0;
      if (beat) begin
        lanes_d[0] = bit_in;
        sel_d      = SEL_W'(1);
      end
    end else if (beat) begin
      if (at_last) begin
        word_d  = {bit_in, lanes_q};
        wvld_d  = 1'b1;
        lanes_d = '0;
        sel_d   = '0;
      end else begin
        lanes_d[sel_q] = bit_in;
        sel_d          = sel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      lanes_q <= '0;
      word_q  <= '0;
      wvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      lanes_q <= lanes_d;
      word_q  <= word_d;
      wvld_q  <= wvld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign sel_o      = sel_q;
  assign word_o     = word_q;
  assign word_valid = wvld_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: cycle reference model,
// word scoreboard, directed cases and random gaps.
module tb_demux8_deser;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [2:0] sel_o;
  logic [7:0] word_o;
  logic       word_valid;
  logic       word_ready;
  logic       frame_err;

  demux8_deser #(.LANES(8), .SEL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .sel_o       (sel_o),
    .word_o      (word_o),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int nwords = 0;
  bit chk_en = 1'b0;

  logic [2:0] m_sel;
  logic [7:0] m_acc;
  logic [7:0] m_word;
  logic       m_wv;
  logic       m_ferr;

  logic [7:0] sb[$];
  logic [7:0] got[$];
  int         gotcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic fs, input logic bv,
                      input logic b, input logic wr, output logic acc);
    logic       rdy;
    logic [7:0] e;
    rst         = r;
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = b;
    word_ready  = wr;
    #4;
    rdy = fs || !(m_sel == 3'd7 && m_wv && !wr);
    if (chk_en) begin
      chk("bit_ready", {31'b0, bit_ready}, {31'b0, rdy});
      chk("sel_o", {29'b0, sel_o}, {29'b0, m_sel});
      chk("word_valid", {31'b0, word_valid}, {31'b0, m_wv});
      chk("word_o", {24'b0, word_o}, {24'b0, m_word});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
      if (word_valid === 1'b1 && wr) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_word", {24'b0, word_o}, {24'b0, e});
        end
        got.push_back(word_o);
        gotcyc.push_back(cyc);
      end
    end
    acc = bv && rdy;
    if (r) begin
      m_sel = '0; m_acc = '0; m_word = '0;
      m_wv = 1'b0; m_ferr = 1'b0;
      sb.delete();
    end else begin
      m_ferr = fs && (m_sel != 3'd0);
      if (m_wv && wr) m_wv = 1'b0;
      if (fs) begin
        m_acc = '0;
        m_sel = 3'd0;
        if (acc) begin
          m_acc[0] = b;
          m_sel = 3'd1;
        end
      end else if (acc) begin
        m_acc[m_sel] = b;
        if (m_sel == 3'd7) begin
          m_word = m_acc;
          m_wv = 1'b1;
          m_acc = '0;
          m_sel = 3'd0;
          sb.push_back(m_word);
          nwords++;
        end else begin
          m_sel = m_sel + 3'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic wr);
    logic a;
    step(1'b0, 1'b0, 1'b0, 1'b0, wr, a);
  endtask

  task automatic send_bits(input logic [7:0] w, input int from,
                           input int to, input logic fs,
                           input logic wr);
    logic a;
    int   tries;
    for (int k = from; k <= to; k++) begin
      tries = 0;
      do begin
        step(1'b0, fs && (k == from) && (tries == 0), 1'b1, w[k], wr, a);
        tries++;
      end while (!a && tries < 50);
      if (!a) chk("accept_tmo", {31'b0, a}, 32'd1);
    end
  endtask

  logic [7:0] exp4[4];
  logic       a0;
  int         start_w;
  int         rc;

  initial begin
    m_sel = '0; m_acc = '0; m_word = '0; m_wv = 1'b0; m_ferr = 1'b0;
    rst = 1'b1; frame_start = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; word_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a0);
    chk("rst_sel", {29'b0, sel_o}, 32'd0);
    chk("rst_wv", {31'b0, word_valid}, 32'd0);
    chk("rst_word", {24'b0, word_o}, 32'd0);
    chk("rst_rdy", {31'b0, bit_ready}, 32'd1);
    chk("rst_ferr", {31'b0, frame_err}, 32'd0);

    // basic
    send_bits(8'hA5, 0, 7, 1'b1, 1'b1);
    chk("basic_wv", {31'b0, word_valid}, 32'd1);
    chk("basic_word", {24'b0, word_o}, 32'hA5);
    chk("basic_sel", {29'b0, sel_o}, 32'd0);
    idle(1'b1);

    // backpressure
    send_bits(8'h3C, 0, 7, 1'b1, 1'b0);
    send_bits(8'hC3, 0, 6, 1'b0, 1'b0);
    bit_valid = 1'b1; word_ready = 1'b0; frame_start = 1'b0;
    #1;
    chk("bp_stall", {31'b0, bit_ready}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    chk("bp_hold", {24'b0, word_o}, 32'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a0);
    chk("bp_new", {24'b0, word_o}, 32'hC3);
    chk("bp_wv", {31'b0, word_valid}, 32'd1);
    idle(1'b1);

    // streaming
    got.delete(); gotcyc.delete();
    exp4[0] = 8'h00; exp4[1] = 8'hFF; exp4[2] = 8'h01; exp4[3] = 8'h80;
    for (int i = 0; i < 4; i++) send_bits(exp4[i], 0, 7, i == 0, 1'b1);
    idle(1'b1);
    chk("str_cnt", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("str_word", {24'b0, got[i]}, {24'b0, exp4[i]});
      if (i > 0) chk("str_gap", 32'(gotcyc[i] - gotcyc[i-1]), 32'd8);
    end

    // resync
    got.delete();
    send_bits(8'h1F, 0, 4, 1'b1, 1'b1);
    send_bits(8'h5A, 0, 0, 1'b1, 1'b1);
    chk("rs_ferr1", {31'b0, frame_err}, 32'd1);
    send_bits(8'h5A, 1, 1, 1'b0, 1'b1);
    chk("rs_ferr0", {31'b0, frame_err}, 32'd0);
    send_bits(8'h5A, 2, 7, 1'b0, 1'b1);
    chk("rs_word", {24'b0, word_o}, 32'h5A);
    idle(1'b1);
    chk("rs_cnt", 32'(got.size()), 32'd1);

    // reset mid-word
    got.delete();
    send_bits(8'h0F, 0, 3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a0);
    chk("mr_sel", {29'b0, sel_o}, 32'd0);
    chk("mr_wv", {31'b0, word_valid}, 32'd0);
    idle(1'b1);
    send_bits(8'h96, 0, 7, 1'b0, 1'b1);
    chk("mr_word", {24'b0, word_o}, 32'h96);
    idle(1'b1);
    chk("mr_cnt", 32'(got.size()), 32'd1);

    // random gaps
    start_w = nwords;
    rc = 0;
    while (nwords - start_w < 1000 && rc < 60000) begin
      step(1'b0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 70, 1'($urandom),
           $urandom_range(0, 99) < 60, a0);
      rc++;
    end
    chk("rand_words", {31'b0, (nwords - start_w) >= 1000}, 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
